// File: rtl/voter_session_if.sv
// Handshake and datapath signals between the voting session controller and its environment.
// The external voter datapath supplies verdict from the ballot this block drives.
interface voter_session_if;
    logic       start;
    logic       vote_valid;
    logic [1:0] vote_id;
    logic       vote_val;
    logic       ack;
    logic [3:0] ballot;
    logic [2:0] verdict;
    logic [2:0] result;
    logic       result_valid;
    logic       busy;
    logic       timed_out;
    logic       dup_err;

    modport master (
        output start, vote_valid, vote_id, vote_val, ack, verdict,
        input  ballot, result, result_valid, busy, timed_out, dup_err
    );

    modport slave (
        input  start, vote_valid, vote_id, vote_val, ack, verdict,
        output ballot, result, result_valid, busy, timed_out, dup_err
    );
endinterface

// File: rtl/voter_session_ctrl.sv
// Voting session controller: collects one vote per voter, closes on full ballot or timeout,
// latches the external voter verdict and holds it until acknowledged.
//
//   state     | meaning
//   S_IDLE    | waiting for start; ballot keeps last session's value
//   S_COLLECT | accepting votes, timer counting toward the budget
//   S_EVAL    | one cycle with ballot frozen; verdict captured at its end
//   S_DONE    | result held until ack
module voter_session_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    voter_session_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EVAL    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [7:0] LP_TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_ballot;
    logic [3:0] r_cast_mask;
    logic [7:0] r_timer;
    logic [2:0] r_result;
    logic       r_timed_out;
    logic       r_dup_err;

    logic       w_in_collect;
    logic       w_vote_new;
    logic       w_vote_dup;
    logic [3:0] w_mask_nxt;
    logic       w_all_cast;
    logic       w_timeout;

    assign w_in_collect = (r_state == S_COLLECT);
    assign w_vote_new   = w_in_collect && bus.vote_valid && !r_cast_mask[bus.vote_id];
    assign w_vote_dup   = w_in_collect && bus.vote_valid &&  r_cast_mask[bus.vote_id];
    assign w_mask_nxt   = r_cast_mask | (w_vote_new ? (4'b0001 << bus.vote_id) : 4'b0000);
    assign w_all_cast   = (w_mask_nxt == 4'b1111);
    assign w_timeout    = (r_timer == LP_TIMER_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if (w_all_cast || w_timeout) w_state_nxt = S_EVAL;
            end
            S_EVAL: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (bus.ack) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ballot    <= 4'b0000;
            r_cast_mask <= 4'b0000;
            r_timer     <= 8'd0;
            r_result    <= 3'b000;
            r_timed_out <= 1'b0;
            r_dup_err   <= 1'b0;
        end else begin
            r_dup_err <= w_vote_dup;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ballot    <= 4'b0000;
                        r_cast_mask <= 4'b0000;
                        r_timer     <= 8'd0;
                        r_timed_out <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (w_vote_new) begin
                        r_ballot[bus.vote_id] <= bus.vote_val;
                    end
                    r_cast_mask <= w_mask_nxt;
                    r_timer     <= r_timer + 8'd1;
                    // A full ballot wins over a simultaneous timeout.
                    if (w_all_cast || w_timeout) begin
                        r_timed_out <= !w_all_cast;
                    end
                end
                S_EVAL: begin
                    r_result <= bus.verdict;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ballot       = r_ballot;
    assign bus.result       = r_result;
    assign bus.result_valid = (r_state == S_DONE);
    assign bus.busy         = w_in_collect || (r_state == S_EVAL);
    assign bus.timed_out    = r_timed_out && (r_state == S_DONE);
    assign bus.dup_err      = r_dup_err;

endmodule
